// File: rtl/sample_pkg.sv
// Shared constants and state encoding for the sample streamer.
// Imported by the interface, the sample RAM and the streamer top.
package sample_pkg;

    localparam int N     = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DIV_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sample_streamer_if.sv
// Control, write and sample-stream bundle of the sample streamer.
// master drives writes/control and sees the stream; slave is the streamer.
interface sample_streamer_if;
    import sample_pkg::*;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [N-1:0]     wr_data;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [AW-1:0]    last_addr;
    logic [DIV_W-1:0] rate_div;
    logic [N-1:0]     sample_out;
    logic             sample_valid;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data,
        output start, stop, loop_en, last_addr, rate_div,
        input  sample_out, sample_valid, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  start, stop, loop_en, last_addr, rate_div,
        output sample_out, sample_valid, busy, done
    );

endinterface

// File: rtl/sample_ram.sv
// DEPTH x N simple dual-port sample memory, registered read-before-write.
// Ports: clk, reset (clears read register only), wr_*, rd_en, rd_addr, rd_data.
module sample_ram
    import sample_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    logic [N-1:0] mem [DEPTH];

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between reads; same-address
    // write on the read edge returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_streamer.sv
// Programmable-rate sample player feeding the FIR data_in.
// Ports: clk, reset (sync, active-high), bus (sample_streamer_if.slave).
module sample_streamer
    import sample_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    sample_streamer_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic [AW-1:0]    rd_addr;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] rate_q;
    logic [AW-1:0]    last_q;
    logic             loop_q;
    logic             valid_q;
    logic             done_q;
    logic             tick;
    logic             launch;
    logic             last_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // stop wins over a tick due on the same edge.
    always_comb begin
        next_state = state;
        tick       = 1'b0;
        launch     = 1'b0;
        last_hit   = (rd_addr == last_q);
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    launch     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    next_state = IDLE;
                end else if (div_cnt == rate_q) begin
                    tick = 1'b1;
                    if (last_hit && !loop_q) begin
                        next_state = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            div_cnt <= '0;
            rate_q  <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= tick;
            done_q  <= tick && last_hit && !loop_q;
            if (launch) begin
                rate_q  <= bus.rate_div;
                last_q  <= bus.last_addr;
                loop_q  <= bus.loop_en;
                rd_addr <= '0;
                div_cnt <= '0;
            end else if (state == RUN && !bus.stop) begin
                if (tick) begin
                    div_cnt <= '0;
                    rd_addr <= last_hit ? '0 : rd_addr + AW'(1);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // The RAM read register is sample_out itself, loaded only on a tick.
    sample_ram u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (tick),
        .rd_addr (rd_addr),
        .rd_data (bus.sample_out)
    );

    assign bus.sample_valid = valid_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state == RUN);

endmodule

// File: doc/sample_streamer.md
Name: sample_streamer

Overview:
Synthesizable sample source that sits directly upstream of the FIR filter and drives the filter's data_in input. Holds a loadable 32-entry sample memory. Plays samples out at a programmable rate as a single pass or a continuous loop, with a one-cycle valid strobe per sample. Replaces file-driven stimulus so the filter can be exercised on hardware.

Parameters:
N, 16, sample width; must match the FIR data width
DEPTH, 32, number of sample memory entries
AW, 5, address width, log2(DEPTH)
DIV_W, 8, width of the rate divider

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  sample memory write strobe
wr_addr  in  AW  write address
wr_data  in  N  write data
start  in  1  begin playback; acted on only in IDLE
stop  in  1  abort playback
loop_en  in  1  1 = wrap to address 0 after last_addr; latched at start
last_addr  in  AW  final address played, inclusive; latched at start
rate_div  in  DIV_W  sample period minus 1, in clk cycles; latched at start
sample_out  out  N  current sample, connects to FIR data_in
sample_valid  out  1  one-cycle strobe, new sample on sample_out
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on completion of a non-loop pass

Behaviour:
- Reset values: sample_out=0, sample_valid=0, busy=0, done=0. Internal rd_addr=0, div_cnt=0, state=IDLE.
- Reset does not clear memory contents. Reset mid-playback returns everything to reset values at the next edge.
- Write port:
  - Writes are accepted in any state.
  - Memory read is registered.
  - A same-cycle read and write to the same address returns the old data (read-before-write).
- FSM has two states, IDLE and RUN.
- IDLE -> RUN: on an edge with start=1 and stop=0.
  - Latches rate_div, last_addr and loop_en.
  - Clears rd_addr and div_cnt.
  - Sets busy=1.
- In RUN, each edge:
  - If div_cnt==rate_div_q, a tick occurs and div_cnt<=0. Otherwise div_cnt<=div_cnt+1.
- Tick:
  - sample_out<=mem[rd_addr] and sample_valid<=1 for exactly one cycle.
  - sample_valid stays high continuously when rate_div=0.
  - If rd_addr!=last_q, then rd_addr<=rd_addr+1.
  - If rd_addr==last_q and loop_q=1, then rd_addr<=0.
  - If rd_addr==last_q and loop_q=0, go to IDLE: busy<=0 and done<=1 on the same edge as the final sample_valid.
- Timing: start is sampled at edge T0. The first sample_valid is asserted after edge T(rate_div+1). Sample period is rate_div+1 cycles.
- sample_out holds its value between ticks and after playback ends.
- stop in RUN:
  - Go to IDLE at the next edge with busy<=0.
  - A tick due on that edge is suppressed: no sample_valid, no done.
- stop and start together in IDLE: stay in IDLE.
- start in RUN: ignored; latched values are unchanged.
- Address rd_addr is AW bits wide. last_addr=DEPTH-1 wraps naturally. Addresses above last_q are never read.
- div_cnt is DIV_W bits unsigned and cannot overflow, since it compares before incrementing.

Decomposition:
- Shared package sample_pkg holds:
  - constants N, DEPTH, AW, DIV_W
  - state encoding IDLE=1'b0, RUN=1'b1
- One sub-module: sample_ram.
  - Simple dual-port: one write port, one registered read port, read-before-write.
  - Instantiated once by sample_streamer.
  - The FSM, divider and address counter stay in the top level.

Test Plan:
1. Write mem[i]=3*i for i=0..31. Start with rate_div=0, last_addr=31, loop_en=0. Expect sample_valid high for 32 consecutive cycles with samples 0,3,...,93. Expect done=1 with sample 93, then busy=0 and sample_out held at 93.
2. Start with rate_div=3, last_addr=3, loop_en=0. Expect the first valid 4 cycles after start, then one valid every 4 cycles, with samples 0,3,6,9. Expect done with 9.
3. Start with rate_div=1, last_addr=2, loop_en=1. Expect 0,3,6,0,3,6,... every 2 cycles. Assert stop on a tick cycle: no valid on that edge, busy=0 next cycle, done never asserted.
4. Assert reset while busy at the 10th sample. Expect all outputs 0 at the next edge. A new start with rate_div=0 resumes from address 0 and outputs 0, and memory contents persist.
5. During a run with rate_div=2, write mem[5]=16'hABCD before address 5 is read. Expect the 6th sample to be 16'hABCD. Assert start mid-run: expect no restart and an unchanged period.
6. Write and read address 7 in the same cycle (old value 21, new 16'h1234). Expect output 21 on that read; a later looped read returns 16'h1234.
